jstk_spi_ctrl: RTL and testbench
================================

JSTK_SPI_CTRL -- requirements
Module: jstk_spi_ctrl

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 5, bytes per transaction (1..8).
REQ-002 SHALL have parameter SS_SETUP, default 2, CLK cycles from SS low to first byte request.
REQ-003 SHALL have parameter GAP, default 2, idle CLK cycles between consecutive bytes.
REQ-004 SHALL have parameter TIMEOUT, default 64, max CLK cycles waiting on any single BUSY_SPI edge.
REQ-005 SHALL have port CLK  in  1  controller and SPI byte-engine clock.
REQ-006 SHALL have port RST  in  1  synchronous reset, active-high.
REQ-007 SHALL have port sndRec  in  1  level request to run one transaction.
REQ-008 SHALL have port DIN  in  8  command byte sent as first byte (LED control).
REQ-009 SHALL have port BUSY_SPI  in  1  BUSY from the mode-0 byte engine.
REQ-010 SHALL have port DOUT_SPI  in  8  received byte from the byte engine.
REQ-011 SHALL have port SS  out  1  slave select, active-low.
REQ-012 SHALL have port getByte  out  1  drives the byte engine sndRec.
REQ-013 SHALL have port sndData  out  8  drives the byte engine DIN.
REQ-014 SHALL have port BUSY  out  1  transaction in progress.
REQ-015 SHALL have port DOUT  out  8*NUM_BYTES  last completed transaction; first received byte in MSBs.
REQ-016 SHALL have port ERR  out  1  one-cycle pulse on timeout abort.

Function
REQ-017 SHALL update all state on rising CLK edges only.
REQ-018 SHALL implement states Idle, Setup, Req, Wait, Gap, Done.
REQ-019 In Idle, SS=1, getByte=0, BUSY=0, byte counter=0, and sndRec=1 SHALL latch DIN, clear the assembly register, go to Setup.
REQ-020 sndRec SHALL be sampled in Idle only; changes elsewhere ignored.
REQ-021 Setup: SS=0, BUSY=1, count SS_SETUP cycles, then Req.
REQ-022 Req: getByte=1; sndData = latched DIN for byte 0, 8'h00 otherwise; stay until BUSY_SPI sampled 1, then Wait.
REQ-023 Wait: getByte=0, sndData held; stay until BUSY_SPI sampled 0, then shift assembly register left 8 with DOUT_SPI in LSBs, increment byte counter, go Gap.
REQ-024 sndData SHALL be stable from Req entry until Wait exit.
REQ-025 Gap: count GAP cycles; then Req if byte counter < NUM_BYTES, else Done.
REQ-026 Done (one cycle): SS=1, BUSY=1, DOUT <= assembly register, then Idle.
REQ-027 DOUT SHALL change only in Done, atomically; never shows partial data.
REQ-028 Per-edge timeout counter SHALL clear on entering Req or Wait; if it reaches TIMEOUT before the awaited BUSY_SPI level, go Done with DOUT unchanged and ERR=1 that cycle.
REQ-029 ERR SHALL be 0 in all other cycles.
REQ-030 SS SHALL be 0 in every state except Idle and Done.
REQ-031 With sndRec held 1, a new transaction SHALL start on the Idle cycle following Done (one Idle cycle minimum between SS-high periods).
REQ-032 Total latency sndRec-to-BUSY-low SHALL be deterministic for a fixed BUSY_SPI response.

Reset
REQ-033 RST=1 at a rising edge SHALL force Idle, SS=1, getByte=0, sndData=0, BUSY=0, DOUT=0, ERR=0, all counters and latches 0.
REQ-034 RST SHALL take effect from any state, including mid-byte; no DOUT update and no ERR on reset abort.

Verification
REQ-035 Bench SHALL model the byte engine (BUSY_SPI high 2 cycles after getByte, high 10 cycles, returns scripted byte).
REQ-036 DIN=8'h81, sndRec pulse, engine returns 11,22,33,44,55 -> sndData 81,00,00,00,00; DOUT=40'h1122334455 after Done; BUSY low next cycle; SS low throughout.
REQ-037 Engine never raises BUSY_SPI on byte 2 -> after TIMEOUT cycles ERR pulses once, SS=1, DOUT keeps prior value, Idle.
REQ-038 RST asserted during byte 3 -> next cycle SS=1, getByte=0, BUSY=0, DOUT=0; new sndRec runs full transaction correctly.
REQ-039 sndRec held high for two transactions with different scripted data -> two Done cycles, SS high at least one Idle cycle between, DOUT updates to second data.
REQ-040 DIN changed mid-transaction -> byte 0 already sent unaffected; next transaction uses new DIN.

Source files
------------

// File: rtl/jstk_spi_ctrl.sv
// Joystick SPI transaction controller.
// Drives a mode-0 SPI byte engine through one framed transaction of NUM_BYTES
// bytes: asserts SS, sends the latched command byte followed by zero fill,
// and assembles the received bytes into DOUT (first byte in the MSBs).
// A per-edge timeout aborts a stalled engine handshake and pulses ERR.
module jstk_spi_ctrl #(
    parameter int NUM_BYTES = 5,
    parameter int SS_SETUP  = 2,
    parameter int GAP       = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   sndRec,
    input  logic [7:0]             DIN,
    input  logic                   BUSY_SPI,
    input  logic [7:0]             DOUT_SPI,
    output logic                   SS,
    output logic                   getByte,
    output logic [7:0]             sndData,
    output logic                   BUSY,
    output logic [8*NUM_BYTES-1:0] DOUT,
    output logic                   ERR
);

    localparam int DW      = 8 * NUM_BYTES;
    // Setup and Gap always occupy at least one cycle so each is a real state.
    localparam int SETUP_N = (SS_SETUP < 1) ? 1 : SS_SETUP;
    localparam int GAP_N   = (GAP < 1) ? 1 : GAP;
    localparam int CNT_MAX = (SETUP_N > GAP_N) ? SETUP_N : GAP_N;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(NUM_BYTES + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_N - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_N - 1);
    localparam logic [BW-1:0] NBYTES     = BW'(NUM_BYTES);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;       // Setup / Gap cycle counter
    logic [BW-1:0]   r_byte_cnt;  // bytes completed in this transaction
    logic [TW-1:0]   r_tmo;       // cycles spent waiting on the current BUSY_SPI edge
    logic [7:0]      r_din;       // command byte captured at transaction start
    logic [DW-1:0]   r_asm;       // received bytes, shifted in from the LSB end

    // Transaction sequencer; every output is a register updated on the
    // transition into the state whose value it reflects.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_tmo      <= '0;
            r_din      <= '0;
            r_asm      <= '0;
            SS         <= 1'b1;
            getByte    <= 1'b0;
            sndData    <= '0;
            BUSY       <= 1'b0;
            DOUT       <= '0;
            ERR        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sndRec) begin
                        r_din      <= DIN;
                        r_asm      <= '0;
                        r_cnt      <= '0;
                        r_byte_cnt <= '0;
                        SS         <= 1'b0;
                        BUSY       <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        // First byte of the frame carries the command.
                        r_cnt   <= '0;
                        r_tmo   <= '0;
                        getByte <= 1'b1;
                        sndData <= r_din;
                        r_state <= S_REQ;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_REQ: begin
                    if (BUSY_SPI) begin
                        getByte <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end else if (r_tmo == TMO_LAST) begin
                        getByte <= 1'b0;
                        SS      <= 1'b1;
                        ERR     <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end

                S_WAIT: begin
                    if (!BUSY_SPI) begin
                        r_asm      <= (r_asm << 8) | DW'(DOUT_SPI);
                        r_byte_cnt <= r_byte_cnt + BW'(1);
                        r_cnt      <= '0;
                        r_state    <= S_GAP;
                    end else if (r_tmo == TMO_LAST) begin
                        SS      <= 1'b1;
                        ERR     <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end

                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (r_byte_cnt < NBYTES) begin
                            // Remaining bytes are zero fill; only byte 0 is a command.
                            r_tmo   <= '0;
                            getByte <= 1'b1;
                            sndData <= 8'h00;
                            r_state <= S_REQ;
                        end else begin
                            SS      <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    // An aborted frame leaves the previous result visible.
                    if (!ERR) begin
                        DOUT <= r_asm;
                    end
                    ERR        <= 1'b0;
                    BUSY       <= 1'b0;
                    r_byte_cnt <= '0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_spi_ctrl.sv
// Bench for jstk_spi_ctrl: byte-engine model plus transaction-level reference.
module tb_jstk_spi_ctrl;

    localparam int NB    = 5;
    localparam int SETUP = 2;
    localparam int GP    = 2;
    localparam int TMO   = 64;
    // Engine raises BUSY_SPI two cycles after it sees getByte, so the
    // controller samples it on its third edge in Req; BUSY_SPI then stays
    // high for ten cycles, which is how long the controller sits in Wait.
    localparam int ENG_REQ  = 3;
    localparam int ENG_WAIT = 10;
    localparam int BYTE_CYC = ENG_REQ + ENG_WAIT + GP;
    localparam int TXN_CYC  = SETUP + NB * BYTE_CYC + 1;

    logic            CLK = 1'b0;
    logic            RST;
    logic            sndRec;
    logic [7:0]      DIN;
    logic            BUSY_SPI;
    logic [7:0]      DOUT_SPI;
    logic            SS;
    logic            getByte;
    logic [7:0]      sndData;
    logic            BUSY;
    logic [8*NB-1:0] DOUT;
    logic            ERR;

    jstk_spi_ctrl #(
        .NUM_BYTES (NB),
        .SS_SETUP  (SETUP),
        .GAP       (GP),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .sndRec   (sndRec),
        .DIN      (DIN),
        .BUSY_SPI (BUSY_SPI),
        .DOUT_SPI (DOUT_SPI),
        .SS       (SS),
        .getByte  (getByte),
        .sndData  (sndData),
        .BUSY     (BUSY),
        .DOUT     (DOUT),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_err = 0;
    int          eng_q[$];      // scripted engine bytes; -1 means never respond
    logic [7:0]  snd_q[$];      // sndData captured at each getByte rise
    int          busy_cyc = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          err_bad  = 0;
    int          ss_bad   = 0;
    int          snd_bad  = 0;
    logic        prev_get = 1'b0;
    logic [7:0]  cur_snd  = 8'h00;
    logic [8*NB-1:0] exp_dout;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_script(input logic [8*NB-1:0] d);
        for (int i = NB - 1; i >= 0; i--) eng_q.push_back(int'(d[8*i +: 8]));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (BUSY && n < 1000);
        chk({tag, "_idle"}, BUSY, 1'b0);
    endtask

    // Byte engine model: drives BUSY_SPI / DOUT_SPI on falling edges.
    initial begin
        int   b;
        logic aborted;
        BUSY_SPI = 1'b0;
        DOUT_SPI = 8'h00;
        forever begin
            @(negedge CLK);
            if (getByte && !RST) begin
                b = (eng_q.size() > 0) ? eng_q.pop_front() : 0;
                aborted = 1'b0;
                if (b < 0) begin
                    while (getByte && !RST) @(negedge CLK);
                end else begin
                    for (int i = 0; i < 12; i++) begin
                        @(negedge CLK);
                        if (RST) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (i == 1) BUSY_SPI = 1'b1;
                    end
                    BUSY_SPI = 1'b0;
                    if (!aborted) DOUT_SPI = b[7:0];
                end
            end
        end
    end

    // Observer: records sent bytes and per-cycle protocol properties.
    initial begin
        forever begin
            @(negedge CLK);
            if (getByte && !prev_get) begin
                snd_q.push_back(sndData);
                cur_snd = sndData;
            end
            if (getByte && prev_get && sndData !== cur_snd) snd_bad++;
            prev_get = getByte;
            if (BUSY) busy_cyc++;
            if (BUSY && SS) done_cnt++;
            if (ERR) err_cnt++;
            if (ERR && !(BUSY && SS)) err_bad++;
            if (!BUSY && !SS) ss_bad++;
        end
    end

    task automatic run_txn(input logic [7:0] din, input logic [8*NB-1:0] data, input string tag);
        int s0, d0, e0, b0;
        s0 = snd_q.size(); d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc;
        push_script(data);
        DIN = din;
        sndRec = 1'b1;
        @(negedge CLK);
        sndRec = 1'b0;
        wait_idle(tag);
        exp_dout = data;
        chk({tag, "_dout"}, DOUT, exp_dout);
        chk({tag, "_nsnd"}, snd_q.size() - s0, NB);
        for (int i = 0; i < NB; i++)
            if (s0 + i < snd_q.size())
                chk($sformatf("%s_snd%0d", tag, i), snd_q[s0+i], (i == 0) ? din : 8'h00);
        chk({tag, "_lat"}, busy_cyc - b0, TXN_CYC);
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_err"}, err_cnt - e0, 0);
        chk({tag, "_ss"}, SS, 1'b1);
    endtask

    initial begin
        int s0, d0, e0, b0, n;
        logic [63:0] r1, r2;
        logic [8*NB-1:0] da, db;

        RST = 1'b1; sndRec = 1'b0; DIN = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_ss", SS, 1'b1);
        chk("rst_get", getByte, 1'b0);
        chk("rst_snd", sndData, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_dout", DOUT, '0);
        chk("rst_err", ERR, 1'b0);
        RST = 1'b0;
        @(negedge CLK);

        // Directed frame.
        run_txn(8'h81, 40'h1122334455, "dir");

        // Random frames.
        for (int k = 0; k < 4; k++) begin
            r1 = {$urandom, $urandom};
            run_txn(8'($urandom), r1[8*NB-1:0], $sformatf("rnd%0d", k));
        end

        // Engine stalls on byte 2: timeout abort, DOUT unchanged.
        s0 = snd_q.size(); d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc;
        eng_q.push_back(8'hA1); eng_q.push_back(8'hB2); eng_q.push_back(-1);
        DIN = 8'h5A; sndRec = 1'b1;
        @(negedge CLK);
        sndRec = 1'b0;
        wait_idle("tmo");
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_done", done_cnt - d0, 1);
        chk("tmo_dout", DOUT, exp_dout);
        chk("tmo_lat", busy_cyc - b0, SETUP + 2 * BYTE_CYC + TMO + 1);
        chk("tmo_nsnd", snd_q.size() - s0, 3);
        chk("tmo_ss", SS, 1'b1);
        eng_q.delete();

        // Reset in the middle of byte 3.
        s0 = snd_q.size(); d0 = done_cnt; e0 = err_cnt;
        r1 = {$urandom, $urandom};
        push_script(r1[8*NB-1:0]);
        DIN = 8'h33; sndRec = 1'b1;
        @(negedge CLK);
        sndRec = 1'b0;
        n = 0;
        while (snd_q.size() - s0 < 3 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("mrst_reach", snd_q.size() - s0, 3);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mrst_ss", SS, 1'b1);
        chk("mrst_get", getByte, 1'b0);
        chk("mrst_busy", BUSY, 1'b0);
        chk("mrst_dout", DOUT, '0);
        chk("mrst_err", ERR, 1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        eng_q.delete();
        exp_dout = '0;
        @(negedge CLK);
        chk("mrst_nodone", done_cnt - d0, 0);
        chk("mrst_noerr", err_cnt - e0, 0);
        r2 = {$urandom, $urandom};
        run_txn(8'hC4, r2[8*NB-1:0], "post_rst");

        // sndRec held for two back-to-back frames.
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cyc; s0 = snd_q.size();
        r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
        da = r1[8*NB-1:0]; db = r2[8*NB-1:0];
        push_script(da); push_script(db);
        DIN = 8'h7E; sndRec = 1'b1;
        @(negedge CLK);
        wait_idle("hold1");
        chk("hold1_dout", DOUT, da);
        chk("hold1_ss", SS, 1'b1);
        @(negedge CLK);
        chk("hold_restart", BUSY, 1'b1);
        sndRec = 1'b0;
        wait_idle("hold2");
        chk("hold2_dout", DOUT, db);
        chk("hold_done", done_cnt - d0, 2);
        chk("hold_err", err_cnt - e0, 0);
        chk("hold_lat", busy_cyc - b0, 2 * TXN_CYC);
        chk("hold_nsnd", snd_q.size() - s0, 2 * NB);
        exp_dout = db;

        // DIN changes mid-frame: byte 0 keeps the old command.
        s0 = snd_q.size();
        r1 = {$urandom, $urandom};
        push_script(r1[8*NB-1:0]);
        DIN = 8'h12; sndRec = 1'b1;
        @(negedge CLK);
        sndRec = 1'b0;
        n = 0;
        while (snd_q.size() - s0 < 2 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        DIN = 8'hE7;
        wait_idle("din");
        chk("din_byte0", (snd_q.size() > s0) ? snd_q[s0] : 8'h00, 8'h12);
        chk("din_dout", DOUT, r1[8*NB-1:0]);
        s0 = snd_q.size();
        r2 = {$urandom, $urandom};
        run_txn(8'hE7, r2[8*NB-1:0], "din_next");

        chk("err_outside_done", err_bad, 0);
        chk("ss_low_idle", ss_bad, 0);
        chk("snd_stable", snd_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
